// File: rtl/cxu_l2_arbiter_pkg.sv
// ============================================================================
// Package : cxu_l2_arbiter_pkg
// Shared types, constants and the round-robin pick helper for the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cxu_l2_arbiter_pkg;

    localparam int ARB_CNT_W   = 32;
    // Tags are sized for the largest supported requester count (N_REQ <= 32).
    localparam int ARB_MAX_REQ = 32;

    typedef logic [$clog2(ARB_MAX_REQ)-1:0] arb_tag_t;

    // Port width for an optional field: zero-width fields become a 1-bit stub.
    function automatic int pw(input int w);
        return (w > 0) ? w : 1;
    endfunction

    // First set bit of valid at or after ptr, wrapping within n requesters.
    function automatic arb_tag_t rr_pick(input logic [ARB_MAX_REQ-1:0] valid,
                                         input arb_tag_t               ptr,
                                         input int                     n);
        arb_tag_t pick;
        logic     found;
        int       idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < ARB_MAX_REQ; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (!found && valid[arb_tag_t'(idx)]) begin
                    pick  = arb_tag_t'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cxu_l2_arbiter_tag_fifo.sv
// ============================================================================
// Module : cxu_l2_arbiter_tag_fifo
// Synchronous FIFO of requester tags recording downstream issue order.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cxu_l2_arbiter_tag_fifo
    import cxu_l2_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  arb_tag_t din,
    output logic     full,
    output logic     empty,
    output arb_tag_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    arb_tag_t         mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + PTR_W'(1);
        if (pop_ok)  rd_d = rd_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/cxu_l2_arbiter.sv
// ============================================================================
// Module : cxu_l2_arbiter
// Round-robin sharing of one CXU-L2 port; responses routed back by tag FIFO.
// Optional: CXU_L2_ARBITER_STATS_EN adds grant_cnt / stall_cnt outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cxu_l2_arbiter
    import cxu_l2_arbiter_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TAG_DEPTH      = 4,
    parameter int CXU_CXU_ID_W   = 0,
    parameter int CXU_STATE_ID_W = 0,
    parameter int CXU_FUNC_ID_W  = 10,
    parameter int CXU_INSN_W     = 0,
    parameter int CXU_DATA_W     = 32,
    parameter int CXU_STATUS_W   = 3
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clk_en,
    input  logic [N_REQ-1:0]                        u_req_valid,
    output logic [N_REQ-1:0]                        u_req_ready,
    input  logic [N_REQ*pw(CXU_CXU_ID_W)-1:0]       u_req_cxu_id,
    input  logic [N_REQ*pw(CXU_STATE_ID_W)-1:0]     u_req_state_id,
    input  logic [N_REQ*pw(CXU_FUNC_ID_W)-1:0]      u_req_func_id,
    input  logic [N_REQ*pw(CXU_INSN_W)-1:0]         u_req_insn,
    input  logic [N_REQ*CXU_DATA_W-1:0]             u_req_data0,
    input  logic [N_REQ*CXU_DATA_W-1:0]             u_req_data1,
    output logic [N_REQ-1:0]                        u_resp_valid,
    input  logic [N_REQ-1:0]                        u_resp_ready,
    output logic [CXU_STATUS_W-1:0]                 u_resp_status,
    output logic [CXU_DATA_W-1:0]                   u_resp_data,
    output logic                                    d_req_valid,
    input  logic                                    d_req_ready,
    output logic [pw(CXU_CXU_ID_W)-1:0]             d_req_cxu_id,
    output logic [pw(CXU_STATE_ID_W)-1:0]           d_req_state_id,
    output logic [pw(CXU_FUNC_ID_W)-1:0]            d_req_func_id,
    output logic [pw(CXU_INSN_W)-1:0]               d_req_insn,
    output logic [CXU_DATA_W-1:0]                   d_req_data0,
    output logic [CXU_DATA_W-1:0]                   d_req_data1,
    input  logic                                    d_resp_valid,
    output logic                                    d_resp_ready,
    input  logic [CXU_STATUS_W-1:0]                 d_resp_status,
    input  logic [CXU_DATA_W-1:0]                   d_resp_data
`ifdef CXU_L2_ARBITER_STATS_EN
    ,
    output logic [N_REQ*ARB_CNT_W-1:0]              grant_cnt,
    output logic [ARB_CNT_W-1:0]                    stall_cnt
`endif
);

    localparam int CID_PW = pw(CXU_CXU_ID_W);
    localparam int SID_PW = pw(CXU_STATE_ID_W);
    localparam int FID_PW = pw(CXU_FUNC_ID_W);
    localparam int INS_PW = pw(CXU_INSN_W);

    arb_tag_t                 rr_ptr_q, rr_ptr_d, lock_w_q, lock_w_d, win, head;
    logic                     lock_q, lock_d;
    logic [ARB_MAX_REQ-1:0]   valid_ext;
    logic                     any_valid, can_issue, req_fire, resp_fire;
    logic                     tag_full, tag_empty, head_ready;

    always_comb begin
        valid_ext = '0;
        for (int i = 0; i < N_REQ; i++) valid_ext[i] = u_req_valid[i];
    end

    // A stalled grant is locked so a newly raised requester cannot preempt it.
    assign win       = lock_q ? lock_w_q : rr_pick(valid_ext, rr_ptr_q, N_REQ);
    assign any_valid = |u_req_valid;
    assign can_issue = rst_n & any_valid & ~tag_full;
    assign req_fire  = can_issue & d_req_ready & clk_en;
    assign resp_fire = d_resp_valid & d_resp_ready;

    assign d_req_valid   = can_issue;
    assign d_resp_ready  = rst_n & clk_en & ~tag_empty & head_ready;
    assign u_resp_status = d_resp_status;
    assign u_resp_data   = d_resp_data;

    always_comb begin
        u_req_ready    = '0;
        u_resp_valid   = '0;
        head_ready     = 1'b0;
        d_req_cxu_id   = '0;
        d_req_state_id = '0;
        d_req_func_id  = '0;
        d_req_insn     = '0;
        d_req_data0    = '0;
        d_req_data1    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == arb_tag_t'(i)) begin
                u_req_ready[i] = req_fire;
                d_req_cxu_id   = u_req_cxu_id[i*CID_PW +: CID_PW];
                d_req_state_id = u_req_state_id[i*SID_PW +: SID_PW];
                d_req_func_id  = u_req_func_id[i*FID_PW +: FID_PW];
                d_req_insn     = u_req_insn[i*INS_PW +: INS_PW];
                d_req_data0    = u_req_data0[i*CXU_DATA_W +: CXU_DATA_W];
                d_req_data1    = u_req_data1[i*CXU_DATA_W +: CXU_DATA_W];
            end
            if (head == arb_tag_t'(i)) begin
                u_resp_valid[i] = rst_n & d_resp_valid & ~tag_empty;
                head_ready      = u_resp_ready[i];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        lock_w_d = lock_w_q;
        if (clk_en) begin
            lock_d   = can_issue & ~d_req_ready;
            lock_w_d = win;
            if (req_fire)
                rr_ptr_d = (win == arb_tag_t'(N_REQ-1)) ? '0 : win + arb_tag_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            lock_q   <= 1'b0;
            lock_w_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            lock_w_q <= lock_w_d;
        end
    end

    cxu_l2_arbiter_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .pop   (resp_fire),
        .din   (win),
        .full  (tag_full),
        .empty (tag_empty),
        .head  (head)
    );

    a_resp_needs_tag: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_resp_valid && tag_empty));

`ifdef CXU_L2_ARBITER_STATS_EN
    logic [N_REQ*ARB_CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [ARB_CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (u_req_ready[i])
                grant_cnt_d[i*ARB_CNT_W +: ARB_CNT_W] =
                    grant_cnt_q[i*ARB_CNT_W +: ARB_CNT_W] + ARB_CNT_W'(1);
        end
        if (clk_en && ((can_issue && !d_req_ready) || (any_valid && tag_full)))
            stall_cnt_d = stall_cnt_q + ARB_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire
